// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: header layout,
// FSM state encoding and the header-pack helper.
package router_pkg;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         MAX_LEN      = 63;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SEND_HDR,
    SEND_PL,
    SEND_PAR,
    GAP
  } state_t;

  // Header byte: len in [7:2], addr in [1:0]
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  function automatic logic [7:0] pack_hdr(input logic [1:0] addr, input logic [5:0] len);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store: DEPTH x 8 register array, one synchronous write port and an
// asynchronous read port. Contents are not reset.
module router_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for the router input port: buffers a whole payload, then emits
// header, payload and parity back-to-back under router busy backpressure.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int DEPTH      = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  input  logic       req_bad_par,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       pkt_sent,
  output logic       req_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        r_state, w_nstate;
  logic [1:0]    r_addr;
  logic [5:0]    r_len;
  logic          r_bad;
  logic [7:0]    r_par;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_data;
  logic          r_vld, r_sent, r_drop, r_req_ready, r_pl_ready;

  logic          w_req_fire, w_bad_req, w_pl_fire, w_last_wr, w_last_rd;
  logic [AW-1:0] w_raddr;
  logic [7:0]    w_rdata, w_data_nxt;
  logic          w_vld_nxt, w_sent_nxt, w_drop_nxt;

  assign w_req_fire = req_valid && r_req_ready;
  assign w_bad_req  = (req_addr == ADDR_INVALID) || (req_len == 6'd0);
  assign w_pl_fire  = pl_valid && r_pl_ready;
  assign w_last_wr  = w_pl_fire && (r_wr_ptr == AW'(r_len - 6'd1));
  assign w_last_rd  = (r_rd_ptr == AW'(r_len - 6'd1));

  router_pkt_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clock   (clock),
    .i_we    (w_pl_fire),
    .i_waddr (r_wr_ptr),
    .i_wdata (pl_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_nstate   = r_state;
    w_data_nxt = r_data;
    w_vld_nxt  = r_vld;
    w_sent_nxt = 1'b0;
    w_drop_nxt = 1'b0;
    w_raddr    = '0;
    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          if (w_bad_req) w_drop_nxt = 1'b1;
          else           w_nstate   = COLLECT;
        end
      end
      COLLECT: begin
        if (w_last_wr) begin
          w_nstate   = SEND_HDR;
          w_data_nxt = pack_hdr(r_addr, r_len);
          w_vld_nxt  = 1'b1;
        end
      end
      SEND_HDR: begin
        if (!busy) begin
          w_nstate   = SEND_PL;
          w_data_nxt = w_rdata;
          w_vld_nxt  = 1'b1;
        end
      end
      SEND_PL: begin
        // Look one entry ahead so the next byte is ready on consume
        w_raddr = r_rd_ptr + 1'b1;
        if (!busy) begin
          if (w_last_rd) begin
            w_nstate   = SEND_PAR;
            w_data_nxt = r_par ^ {7'b0, r_bad};
            w_vld_nxt  = 1'b0;
          end else begin
            w_data_nxt = w_rdata;
          end
        end
      end
      SEND_PAR: begin
        if (!busy) begin
          w_nstate   = (GAP_CYCLES == 0) ? IDLE : GAP;
          w_data_nxt = 8'h00;
          w_sent_nxt = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_bad       <= 1'b0;
      r_par       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_data      <= '0;
      r_vld       <= 1'b0;
      r_sent      <= 1'b0;
      r_drop      <= 1'b0;
      r_req_ready <= 1'b0;
      r_pl_ready  <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_data      <= w_data_nxt;
      r_vld       <= w_vld_nxt;
      r_sent      <= w_sent_nxt;
      r_drop      <= w_drop_nxt;
      r_req_ready <= (w_nstate == IDLE);
      r_pl_ready  <= (w_nstate == COLLECT);
      if (w_req_fire) begin
        r_addr   <= req_addr;
        r_len    <= req_len;
        r_bad    <= req_bad_par;
        r_par    <= pack_hdr(req_addr, req_len);
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end
      if (w_pl_fire) begin
        r_par    <= r_par ^ pl_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (r_state == SEND_PL && !busy && !w_last_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_state == SEND_PAR)  r_gap_cnt <= '0;
      else if (r_state == GAP)  r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  assign req_ready = r_req_ready;
  assign pl_ready  = r_pl_ready;
  assign pkt_valid = r_vld;
  assign data_out  = r_data;
  assign pkt_sent  = r_sent;
  assign req_drop  = r_drop;

endmodule
